// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
// Shared types, constants and helper functions for the NCO front-end that
// feeds the 16-stage rotation CORDIC and un-folds its results.
//   Z_W             : CORDIC angle / data width
//   CORDIC_LAT      : cycles from z_tgt to the matching x_out/y_out
//   PHASE_W_DEFAULT : default phase accumulator width
//   tag_t           : {valid, flip} tag travelling alongside each sample
//   fold_t          : folded angle plus the flip flag
// ---------------------------------------------------------------------------
package cordic_pkg;

    localparam int Z_W             = 16;
    localparam int CORDIC_LAT      = 16;
    localparam int PHASE_W_DEFAULT = 32;

    typedef struct packed {
        logic valid;
        logic flip;
    } tag_t;

    typedef struct packed {
        logic [Z_W-1:0] z;
        logic           flip;
    } fold_t;

    // Fold a full-circle phase into the CORDIC range [-pi/2, pi/2).
    // Quadrants 1 and 2 are rotated by pi; that rotation only toggles
    // p[15], which the folded angle never looks at, so one formula serves
    // every quadrant.
    function automatic fold_t fold_phase(input logic [Z_W-1:0] p);
        fold_t r;
        r.flip = p[Z_W-1] ^ p[Z_W-2];
        r.z    = {p[Z_W-2:0], 1'b0};
        return r;
    endfunction

    // Two's-complement negation that clamps -1.0 to the largest positive
    // code instead of wrapping back to -1.0.
    function automatic logic signed [Z_W-1:0] neg_sat(input logic signed [Z_W-1:0] v);
        if (v == {1'b1, {(Z_W-1){1'b0}}}) begin
            return {1'b0, {(Z_W-1){1'b1}}};
        end
        return -v;
    endfunction

endpackage

// File: rtl/cordic_tag_delay.sv
// ---------------------------------------------------------------------------
// cordic_tag_delay
// Fixed-depth shift register used to carry per-sample tags across the
// CORDIC pipeline.
//   clk : clock
//   clr : synchronous active-high clear of every stage
//   d   : tag entering the line
//   q   : tag leaving the line DEPTH cycles later
// ---------------------------------------------------------------------------
module cordic_tag_delay
    import cordic_pkg::*;
#(
    parameter int DEPTH = CORDIC_LAT,
    parameter int WIDTH = $bits(tag_t)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Clear flushes everything in flight so stale tags never reach the output.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/cordic_nco_frontend.sv
// ---------------------------------------------------------------------------
// cordic_nco_frontend
// Phase-accumulator NCO that drives the rotation CORDIC with a folded angle
// and turns the CORDIC's x/y back into full-circle cos/sin.
//   clk, rst      : clock, synchronous active-high reset
//   cfg_load      : latch fcw_in / phase_ofs_in into the active registers
//   fcw_in        : frequency tuning word (unsigned)
//   phase_ofs_in  : phase offset, 65536 = one turn
//   sync_clr      : zero the accumulator
//   run           : advance the accumulator; marks the issued sample valid
//   z_tgt         : folded angle to the CORDIC (pi/4 = 16384)
//   cx_in, cy_in  : CORDIC x_out / y_out (Q1.15)
//   cos_out, sin_out, out_valid : un-folded result and its valid flag
// ---------------------------------------------------------------------------
module cordic_nco_frontend
    import cordic_pkg::*;
#(
    parameter int PHASE_W    = cordic_pkg::PHASE_W_DEFAULT,
    parameter int CORDIC_LAT = cordic_pkg::CORDIC_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_load,
    input  logic [PHASE_W-1:0]    fcw_in,
    input  logic [Z_W-1:0]        phase_ofs_in,
    input  logic                  sync_clr,
    input  logic                  run,
    output logic signed [Z_W-1:0] z_tgt,
    input  logic signed [Z_W-1:0] cx_in,
    input  logic signed [Z_W-1:0] cy_in,
    output logic signed [Z_W-1:0] cos_out,
    output logic signed [Z_W-1:0] sin_out,
    output logic                  out_valid
);

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] fcw_act;
    logic [Z_W-1:0]     ofs_act;
    logic [Z_W-1:0]     phase;
    fold_t              folded;
    tag_t               issue_tag;
    tag_t               tag_out;

    // The phase is taken from register values before this edge's update,
    // so a sample issued together with sync_clr still carries the old phase.
    assign phase  = acc[PHASE_W-1 -: Z_W] + ofs_act;
    assign folded = fold_phase(phase);

    // Issue stage: config registers, accumulator, angle to the CORDIC and the
    // tag that will meet the CORDIC result. The tag is registered alongside
    // z_tgt so that the delay line only has to span the CORDIC itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            fcw_act   <= '0;
            ofs_act   <= '0;
            z_tgt     <= '0;
            issue_tag <= '0;
        end else begin
            if (cfg_load) begin
                fcw_act <= fcw_in;
                ofs_act <= phase_ofs_in;
            end
            if (sync_clr) begin
                acc <= '0;
            end else if (run) begin
                acc <= acc + fcw_act;
            end
            z_tgt           <= folded.z;
            issue_tag.valid <= run;
            issue_tag.flip  <= folded.flip;
        end
    end

    cordic_tag_delay #(
        .DEPTH (CORDIC_LAT),
        .WIDTH ($bits(tag_t))
    ) u_tag_delay (
        .clk (clk),
        .clr (rst),
        .d   (issue_tag),
        .q   (tag_out)
    );

    // Output stage: undo the pi rotation on flipped samples. Invalid samples
    // still update cos/sin; only out_valid distinguishes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            cos_out   <= '0;
            sin_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (tag_out.flip) begin
                cos_out <= neg_sat(cx_in);
                sin_out <= neg_sat(cy_in);
            end else begin
                cos_out <= cx_in;
                sin_out <= cy_in;
            end
            out_valid <= tag_out.valid;
        end
    end

endmodule
